// File: rtl/wb_sram_burst_slave_pkg.sv
// wb_pkg: shared Wishbone B4 constants and the slave FSM state type.
//   CTI_*  : cycle type identifiers (classic, incrementing, end-of-burst)
//   BTE_*  : burst type extensions (linear, wrap-4/8/16)
//   wb_slv_state_e : states of the SRAM slave controller
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLASSIC = 2'd1,
    BURST   = 2'd2,
    GAP     = 2'd3
  } wb_slv_state_e;

endpackage

// File: rtl/wb_sram_burst_slave_if.sv
// wb_if: Wishbone B4 registered-feedback bus bundle.
//   master modport drives ADR/CTI/BTE/DAT_W/SEL/CYC/STB/WE and receives
//   DAT_R/ACK/ERR; slave modport is the mirror image.
interface wb_if #(
  parameter int unsigned WB_ADDR_WIDTH = 32,
  parameter int unsigned WB_DATA_WIDTH = 32
);
  logic [WB_ADDR_WIDTH-1:0]   ADR;
  logic [2:0]                 CTI;
  logic [1:0]                 BTE;
  logic [WB_DATA_WIDTH-1:0]   DAT_W;
  logic [WB_DATA_WIDTH-1:0]   DAT_R;
  logic [WB_DATA_WIDTH/8-1:0] SEL;
  logic                       CYC;
  logic                       STB;
  logic                       WE;
  logic                       ACK;
  logic                       ERR;

  modport master (
    output ADR, CTI, BTE, DAT_W, SEL, CYC, STB, WE,
    input  DAT_R, ACK, ERR
  );

  modport slave (
    input  ADR, CTI, BTE, DAT_W, SEL, CYC, STB, WE,
    output DAT_R, ACK, ERR
  );
endinterface

// File: rtl/wb_sram_burst_slave_sram.sv
// sram_1rw_be: single-port synchronous RAM, per-byte write enable,
// registered read.
//   clk   : clock
//   rst   : async active-high reset, clears only the read register
//   en    : access enable; with we=1 writes enabled bytes, with we=0 reads
//   we    : write (1) / read (0)
//   be    : byte enables for writes
//   addr  : word address
//   wdata : write data
//   rdata : read data, updated only by a read access, otherwise held
module sram_1rw_be #(
  parameter int unsigned DEPTH_BITS = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DEPTH_BITS-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);
  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_BITS];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            rdata <= '0;
    else if (en && !we) rdata <= mem[addr];
  end
endmodule

// File: rtl/wb_sram_burst_slave.sv
// wb_sram_burst_slave: Wishbone B4 registered-feedback slave backed by an
// on-chip SRAM. Classic cycles and incrementing bursts (linear, wrap-4/8/16)
// with byte selects; ERR for addresses outside the window.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   s   : Wishbone slave port (wb_if.slave)
module wb_sram_burst_slave
  import wb_pkg::*;
#(
  parameter int unsigned              WB_ADDR_WIDTH = 32,
  parameter int unsigned              WB_DATA_WIDTH = 32,
  parameter int unsigned              MEM_ADDR_BITS = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE     = 'h0
) (
  input logic  clk,
  input logic  rst,
  wb_if.slave  s
);
  localparam int unsigned LSB = $clog2(WB_DATA_WIDTH / 8);
  localparam int unsigned WIN = MEM_ADDR_BITS + LSB;

  wb_slv_state_e state_q, state_d;

  logic [MEM_ADDR_BITS-1:0] cur_q, cur_d;
  logic [MEM_ADDR_BITS-1:0] adr_idx, nxt_idx, wrap_mask, ram_addr;
  logic                     err_q, err_d;
  logic                     req, in_range;
  logic                     ram_en, ram_we;
  logic [WB_DATA_WIDTH-1:0] ram_rdata;
  logic                     unused_adr_lsb;

  assign req     = s.CYC && s.STB;
  assign adr_idx = s.ADR[WIN-1:LSB];
  // ADDR_BASE is window-aligned, so the two-sided bound check reduces to
  // matching the address bits above the window.
  assign in_range = (s.ADR[WB_ADDR_WIDTH-1:WIN] == ADDR_BASE[WB_ADDR_WIDTH-1:WIN]);
  assign unused_adr_lsb = &{1'b0, s.ADR[LSB-1:0]};

  // A mask of all ones turns the wrap formula into plain linear increment.
  always_comb begin
    case (s.BTE)
      BTE_WRAP4:  wrap_mask = MEM_ADDR_BITS'(3);
      BTE_WRAP8:  wrap_mask = MEM_ADDR_BITS'(7);
      BTE_WRAP16: wrap_mask = MEM_ADDR_BITS'(15);
      default:    wrap_mask = '1;
    endcase
  end

  assign nxt_idx = (cur_q & ~wrap_mask) | ((cur_q + MEM_ADDR_BITS'(1)) & wrap_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
    end
  end

  // Single SRAM port: during a read burst it is pointed at the next beat so
  // the data is ready with the next ACK; during writes at the current beat.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    err_d    = 1'b0;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = cur_q;
    s.ACK    = 1'b0;
    s.ERR    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          cur_d = adr_idx;
          if (!in_range) begin
            // The error beat reuses the CLASSIC slot, flagged by err_q.
            err_d   = 1'b1;
            state_d = CLASSIC;
          end else begin
            ram_en   = !s.WE;
            ram_addr = adr_idx;
            state_d  = (s.CTI == CTI_INCR) ? BURST : CLASSIC;
          end
        end
      end

      CLASSIC: begin
        if (err_q) begin
          s.ERR = 1'b1;
        end else begin
          s.ACK = 1'b1;
          if (s.WE) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
          end
        end
        state_d = GAP;
      end

      BURST: begin
        if (!s.CYC) begin
          state_d = IDLE;
        end else if (s.STB) begin
          s.ACK = 1'b1;
          cur_d = nxt_idx;
          if (s.WE) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
          end else if (s.CTI == CTI_INCR) begin
            // No prefetch on the final beat so DAT_R holds afterwards.
            ram_en   = 1'b1;
            ram_addr = nxt_idx;
          end
          if (s.CTI != CTI_INCR) state_d = GAP;
        end
      end

      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  sram_1rw_be #(
    .DEPTH_BITS(MEM_ADDR_BITS),
    .DATA_WIDTH(WB_DATA_WIDTH)
  ) u_sram (
    .clk  (clk),
    .rst  (rst),
    .en   (ram_en),
    .we   (ram_we),
    .be   (s.SEL),
    .addr (ram_addr),
    .wdata(s.DAT_W),
    .rdata(ram_rdata)
  );

  assign s.DAT_R = ram_rdata;
endmodule

// File: doc/wb_sram_burst_slave.md
Name: wb_sram_burst_slave

Overview:
- Wishbone B4 registered-feedback slave backed by on-chip single-port SRAM.
- Sits directly downstream of the s0 master port of the 3-master/1-slave interconnect and terminates its traffic.
- Supports classic cycles and incrementing bursts (linear, wrap-4/8/16) with byte selects, at one beat per clock once a burst is running.
- Responds with ERR to addresses outside its window.

Parameters:
- WB_ADDR_WIDTH, 32, Wishbone byte-address width.
- WB_DATA_WIDTH, 32, data width; must be 32 or 64.
- MEM_ADDR_BITS, 10, log2 of memory depth in words (default 1024 words).
- ADDR_BASE, 'h0, byte base address of the window; must be aligned to the window size.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- s  wb_if.slave  -  Wishbone slave port, signals below.
- s.ADR  input  WB_ADDR_WIDTH  byte address.
- s.CTI  input  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst.
- s.BTE  input  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- s.DAT_W  input  WB_DATA_WIDTH  write data.
- s.SEL  input  WB_DATA_WIDTH/8  byte enables.
- s.CYC, s.STB, s.WE  input  1 each  cycle, strobe, write enable.
- s.DAT_R  output  WB_DATA_WIDTH  read data.
- s.ACK, s.ERR  output  1 each  beat acknowledge, error.

Behaviour:
- Reset (async, active-high):
  - ACK, ERR and DAT_R go to 0 immediately.
  - FSM goes to IDLE and discards any in-flight cycle.
  - SRAM contents are not cleared.
- Word index = ADR[MEM_ADDR_BITS+LSB-1:LSB], where LSB = log2(WB_DATA_WIDTH/8).
- A request is in range iff ADDR_BASE <= ADR <= ADDR_BASE + (2**MEM_ADDR_BITS)*(WB_DATA_WIDTH/8) - 1.
- FSM has four states: IDLE, CLASSIC, BURST, GAP.
- IDLE:
  - A request is CYC&STB sampled at edge N.
  - Out of range: ERR=1 in cycle N+1 for one cycle, no write, then GAP.
  - CTI=010 in range: SRAM read issued at ADR, go to BURST, ACK=1 in cycle N+1.
  - Any other CTI: SRAM read issued at ADR, go to CLASSIC, ACK=1 in cycle N+1.
- CLASSIC: ACK is high for exactly one cycle, then the FSM goes to GAP.
- GAP: one cycle with ACK=ERR=0, so a master that holds STB is never double-acked; then IDLE.
- BURST:
  - ACK=1 on every cycle in which CYC&STB=1; one beat completes per ACK.
  - If STB=0 (master wait state): ACK=0 that cycle, beat address held, no SRAM write.
  - A completed beat with CTI=111, or a CTI other than 010, ends the burst, then GAP.
  - CYC=0 at any time aborts to IDLE immediately with no further ACK.
- Next-address generation (per completed beat):
  - Linear: word index +1 modulo 2**MEM_ADDR_BITS.
  - wrap4/8/16: low 2/3/4 bits of the word index increment modulo 4/8/16; upper bits held.
  - The next address is presented to the SRAM in the same cycle as the current ACK, so the next DAT_R is valid with the next ACK (zero-wait-state reads).
- Writes:
  - SRAM write occurs at the edge ending an ACK cycle with WE=1, using the current DAT_W and SEL per byte.
  - SEL=0 bytes are unchanged.
  - ERR cycles never write.
- Reads: DAT_R is valid whenever ACK=1 and WE=0; otherwise DAT_R holds its last value.
- WE is constant within a burst, per protocol; the design does not check this.
- ACK and ERR are never both 1.

Decomposition:
- Package wb_pkg holds:
  - CTI_CLASSIC, CTI_INCR, CTI_EOB constants;
  - BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16 constants;
  - a wb_slv_state_e enum for the FSM states.
- One sub-module, sram_1rw_be:
  - single-port synchronous RAM with per-byte write enable and registered read;
  - parameters DEPTH_BITS and DATA_WIDTH.
- The FSM and address generator stay in the top module.

Test Plan:
- Bench parameters are the defaults with ADDR_BASE='h1000_0000.
- Classic write then read:
  - Write ADR 'h1000_0010, DAT_W 'hDEADBEEF, SEL 'hF; later classic read of the same address.
  - Required: ACK one cycle after STB each time, then ACK low for one cycle; read DAT_R='hDEADBEEF.
- Byte enables:
  - Write 'h11223344 with SEL 'hF, then 'hAABBCCDD with SEL 'b0101, then read.
  - Required: read DAT_R='h11BB33DD.
- Linear burst:
  - 4-beat incrementing write at 'h1000_0000, data 1,2,3,4, last beat CTI=111.
  - Then a 4-beat read with STB dropped for one cycle after beat 2.
  - Required: ACK on 4 consecutive cycles for the write; read returns 1,2,3,4 with ACK low only during the wait cycle.
- Wrap-4 burst:
  - Read burst BTE=01 starting at word 2 (ADR 'h1000_0008).
  - Required: data from words 2,3,0,1 in that order.
- Out of range:
  - Read at 'h1000_1000 and write at 'h0FFF_FFFC.
  - Required: ERR=1 one cycle after STB, ACK=0, memory unchanged on readback.
- Abort and reset:
  - Drop CYC after beat 2 of an 8-beat burst: no further ACK, and the next classic read acks normally.
  - Assert rst mid-burst: ACK=0 immediately, SRAM data written before the reset is preserved.
